// File: rtl/rob_retire.sv
// In-order reorder buffer: dual-lane dispatch, multi-port completion, dual-lane retire.
// Retire results leave as registered one-cycle pulses to the committed RAT and the free list.
module rob_retire #(
    parameter int unsigned ROB_DEPTH         = 16,
    parameter int unsigned DISP_PRTS         = 2,
    parameter int unsigned RET_PRTS          = 2,
    parameter int unsigned NUM_CMPLT_PRTS    = 4,
    parameter int unsigned NUM_PHYSICAL_REGS = 64,
    parameter int unsigned ISA_REG_W         = 5,
    localparam int unsigned TW               = $clog2(ROB_DEPTH),
    localparam int unsigned PW               = $clog2(NUM_PHYSICAL_REGS)
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic [DISP_PRTS-1:0]                   i_disp_vld,
    input  logic [DISP_PRTS-1:0]                   i_disp_has_dst,
    input  logic [DISP_PRTS-1:0][ISA_REG_W-1:0]    i_disp_isa_dst,
    input  logic [DISP_PRTS-1:0][PW-1:0]           i_disp_new_pr,
    input  logic [DISP_PRTS-1:0][PW-1:0]           i_disp_old_pr,
    output logic                                   o_disp_rdy,
    output logic [DISP_PRTS-1:0][TW-1:0]           o_disp_tag,
    input  logic [NUM_CMPLT_PRTS-1:0]              i_cmplt_vld,
    input  logic [NUM_CMPLT_PRTS-1:0][TW-1:0]      i_cmplt_tag,
    output logic [NUM_PHYSICAL_REGS-1:0]           o_free_pr,
    output logic [RET_PRTS-1:0]                    o_ratc_we,
    output logic [RET_PRTS-1:0][ISA_REG_W-1:0]     o_ratc_isa,
    output logic [RET_PRTS-1:0][PW-1:0]            o_ratc_pr,
    output logic [TW:0]                            o_rob_cnt,
    output logic                                   o_empty
);

    logic [ROB_DEPTH-1:0]         r_vld;
    logic [ROB_DEPTH-1:0]         r_done;
    logic [ROB_DEPTH-1:0]         r_has_dst;
    logic [ISA_REG_W-1:0]         r_isa    [ROB_DEPTH];
    logic [PW-1:0]                r_new_pr [ROB_DEPTH];
    logic [PW-1:0]                r_old_pr [ROB_DEPTH];
    logic [TW-1:0]                r_head;
    logic [TW-1:0]                r_tail;
    logic [TW:0]                  r_cnt;
    logic                         r_empty;
    logic [NUM_PHYSICAL_REGS-1:0] r_free_pr;
    logic [RET_PRTS-1:0]          r_ratc_we;
    logic [RET_PRTS-1:0][ISA_REG_W-1:0] r_ratc_isa;
    logic [RET_PRTS-1:0][PW-1:0]  r_ratc_pr;

    logic                         w_disp_acc;
    logic [TW-1:0]                w_tag_run;
    logic [DISP_PRTS-1:0][TW-1:0] w_disp_tag;
    logic [TW:0]                  w_disp_n;
    logic                         w_ret_run;
    logic [RET_PRTS-1:0]          w_ret;
    logic [RET_PRTS-1:0][TW-1:0]  w_ret_idx;
    logic [TW:0]                  w_ret_n;
    logic [TW:0]                  w_cnt_nxt;
    logic [NUM_PHYSICAL_REGS-1:0] w_free_pr;
    logic [RET_PRTS-1:0]          w_ratc_we;
    logic [RET_PRTS-1:0][ISA_REG_W-1:0] w_ratc_isa;
    logic [RET_PRTS-1:0][PW-1:0]  w_ratc_pr;

    // Full check uses the pre-edge count only; slots freed by retire become usable next cycle.
    assign w_disp_acc = !i_rst && (r_cnt <= (TW+1)'(ROB_DEPTH - DISP_PRTS));

    always_comb begin
        w_tag_run = r_tail;
        w_disp_n  = '0;
        for (int i = 0; i < DISP_PRTS; i++) begin
            w_disp_tag[i] = w_tag_run;
            if (i_disp_vld[i]) begin
                w_tag_run = w_tag_run + TW'(1);
                w_disp_n  = w_disp_n + (TW+1)'(1);
            end
        end
    end

    // Lane k retires only if every older lane in this cycle also retires.
    always_comb begin
        w_ret_run  = 1'b1;
        w_ret_n    = '0;
        w_free_pr  = '0;
        w_ratc_we  = '0;
        w_ratc_isa = '0;
        w_ratc_pr  = '0;
        for (int k = 0; k < RET_PRTS; k++) begin
            w_ret_idx[k] = r_head + TW'(k);
            w_ret_run    = w_ret_run & r_vld[w_ret_idx[k]] & r_done[w_ret_idx[k]];
            w_ret[k]     = w_ret_run;
            if (w_ret_run) begin
                w_ret_n = w_ret_n + (TW+1)'(1);
                if (r_has_dst[w_ret_idx[k]]) begin
                    w_ratc_we[k]                       = 1'b1;
                    w_ratc_isa[k]                      = r_isa[w_ret_idx[k]];
                    w_ratc_pr[k]                       = r_new_pr[w_ret_idx[k]];
                    w_free_pr[r_old_pr[w_ret_idx[k]]]  = 1'b1;
                end
            end
        end
    end

    assign w_cnt_nxt = r_cnt + (w_disp_acc ? w_disp_n : '0) - w_ret_n;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_cnt      <= '0;
            r_empty    <= 1'b1;
            r_vld      <= '0;
            r_done     <= '0;
            r_free_pr  <= '0;
            r_ratc_we  <= '0;
            r_ratc_isa <= '0;
            r_ratc_pr  <= '0;
        end else begin
            for (int c = 0; c < NUM_CMPLT_PRTS; c++) begin
                if (i_cmplt_vld[c] && r_vld[i_cmplt_tag[c]]) begin
                    r_done[i_cmplt_tag[c]] <= 1'b1;
                end
            end
            for (int k = 0; k < RET_PRTS; k++) begin
                if (w_ret[k]) begin
                    r_vld[w_ret_idx[k]]  <= 1'b0;
                    r_done[w_ret_idx[k]] <= 1'b0;
                end
            end
            if (w_disp_acc) begin
                for (int i = 0; i < DISP_PRTS; i++) begin
                    if (i_disp_vld[i]) begin
                        r_vld[w_disp_tag[i]]  <= 1'b1;
                        r_done[w_disp_tag[i]] <= 1'b0;
                    end
                end
                r_tail <= r_tail + w_disp_n[TW-1:0];
            end
            r_head     <= r_head + w_ret_n[TW-1:0];
            r_cnt      <= w_cnt_nxt;
            r_empty    <= (w_cnt_nxt == '0);
            r_free_pr  <= w_free_pr;
            r_ratc_we  <= w_ratc_we;
            r_ratc_isa <= w_ratc_isa;
            r_ratc_pr  <= w_ratc_pr;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_disp_acc) begin
            for (int i = 0; i < DISP_PRTS; i++) begin
                if (i_disp_vld[i]) begin
                    r_has_dst[w_disp_tag[i]] <= i_disp_has_dst[i];
                    r_isa[w_disp_tag[i]]     <= i_disp_isa_dst[i];
                    r_new_pr[w_disp_tag[i]]  <= i_disp_new_pr[i];
                    r_old_pr[w_disp_tag[i]]  <= i_disp_old_pr[i];
                end
            end
        end
    end

    assign o_disp_rdy = w_disp_acc;
    assign o_disp_tag = w_disp_tag;
    assign o_free_pr  = r_free_pr;
    assign o_ratc_we  = r_ratc_we;
    assign o_ratc_isa = r_ratc_isa;
    assign o_ratc_pr  = r_ratc_pr;
    assign o_rob_cnt  = r_cnt;
    assign o_empty    = r_empty;

endmodule

// File: tb/tb_rob_retire.sv
// Bench for rob_retire: directed scenarios plus random traffic against a queue-based ROB model.
module tb_rob_retire;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic [1:0]      i_disp_vld, i_disp_has_dst;
    logic [1:0][4:0] i_disp_isa_dst;
    logic [1:0][5:0] i_disp_new_pr, i_disp_old_pr;
    logic            o_disp_rdy;
    logic [1:0][3:0] o_disp_tag;
    logic [3:0]      i_cmplt_vld;
    logic [3:0][3:0] i_cmplt_tag;
    logic [63:0]     o_free_pr;
    logic [1:0]      o_ratc_we;
    logic [1:0][4:0] o_ratc_isa;
    logic [1:0][5:0] o_ratc_pr;
    logic [4:0]      o_rob_cnt;
    logic            o_empty;
    logic [93:0]     dut_out;

    rob_retire #(
        .ROB_DEPTH(16), .DISP_PRTS(2), .RET_PRTS(2), .NUM_CMPLT_PRTS(4),
        .NUM_PHYSICAL_REGS(64), .ISA_REG_W(5)
    ) u_dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_disp_vld(i_disp_vld), .i_disp_has_dst(i_disp_has_dst),
        .i_disp_isa_dst(i_disp_isa_dst), .i_disp_new_pr(i_disp_new_pr),
        .i_disp_old_pr(i_disp_old_pr), .o_disp_rdy(o_disp_rdy), .o_disp_tag(o_disp_tag),
        .i_cmplt_vld(i_cmplt_vld), .i_cmplt_tag(i_cmplt_tag), .o_free_pr(o_free_pr),
        .o_ratc_we(o_ratc_we), .o_ratc_isa(o_ratc_isa), .o_ratc_pr(o_ratc_pr),
        .o_rob_cnt(o_rob_cnt), .o_empty(o_empty)
    );

    always #5 i_clk = ~i_clk;

    assign dut_out = {o_free_pr, o_ratc_we, o_ratc_isa, o_ratc_pr, o_rob_cnt, o_empty};

    // Reference model: age-ordered queue of in-flight instructions.
    typedef struct {
        logic [3:0] tag;
        logic       has_dst;
        logic [4:0] isa;
        logic [5:0] npr;
        logic [5:0] opr;
        logic       done;
    } ent_t;

    ent_t            q[$];
    int              m_tail;
    int              n_chk = 0;
    int              n_fail = 0;
    logic [5:0]      pr_ctr = '0;
    logic [63:0]     e_free;
    logic [1:0]      e_we;
    logic [1:0][4:0] e_isa;
    logic [1:0][5:0] e_pr;

    function automatic logic exp_rdy();
        return !i_rst && (q.size() <= 14);
    endfunction

    function automatic logic [3:0] exp_tag(input int lane);
        int t = m_tail;
        for (int j = 0; j < lane; j++) if (i_disp_vld[j]) t++;
        return 4'(t);
    endfunction

    function automatic logic [93:0] exp_out();
        return {e_free, e_we, e_isa, e_pr, 5'(q.size()), q.size() == 0};
    endfunction

    // Advance the model by one edge from the current inputs, then step the DUT.
    task automatic clk_edge();
        int   n;
        logic rdy;
        ent_t e;
        rdy    = exp_rdy();
        e_free = '0; e_we = '0; e_isa = '0; e_pr = '0;
        if (i_rst) begin
            q.delete();
            m_tail = 0;
        end else begin
            n = 0;
            while (n < 2 && n < q.size() && q[n].done) n++;
            for (int k = 0; k < n; k++) begin
                if (q[k].has_dst) begin
                    e_we[k]          = 1'b1;
                    e_isa[k]         = q[k].isa;
                    e_pr[k]          = q[k].npr;
                    e_free[q[k].opr] = 1'b1;
                end
            end
            repeat (n) q.delete(0);
            for (int c = 0; c < 4; c++)
                if (i_cmplt_vld[c])
                    foreach (q[j]) if (q[j].tag == i_cmplt_tag[c]) q[j].done = 1'b1;
            if (rdy) begin
                for (int i = 0; i < 2; i++) begin
                    if (i_disp_vld[i]) begin
                        e.tag = 4'(m_tail); e.has_dst = i_disp_has_dst[i];
                        e.isa = i_disp_isa_dst[i]; e.npr = i_disp_new_pr[i];
                        e.opr = i_disp_old_pr[i]; e.done = 1'b0;
                        q.push_back(e);
                        m_tail++;
                    end
                end
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_disp_vld = '0; i_disp_has_dst = '0; i_disp_isa_dst = '0;
        i_disp_new_pr = '0; i_disp_old_pr = '0; i_cmplt_vld = '0; i_cmplt_tag = '0;
    endtask

    task automatic set_lane(input int i, input logic h, input logic [4:0] isa,
                            input logic [5:0] np, input logic [5:0] op);
        i_disp_vld[i] = 1'b1; i_disp_has_dst[i] = h; i_disp_isa_dst[i] = isa;
        i_disp_new_pr[i] = np; i_disp_old_pr[i] = op;
    endtask

    task automatic cmplt(input int p, input logic [3:0] t);
        i_cmplt_vld[p] = 1'b1; i_cmplt_tag[p] = t;
    endtask

    task automatic do_reset();
        idle();
        i_rst = 1'b1;
        clk_edge();
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        i_rst = 1'b1;
        set_lane(0, 1'b1, 5'd1, 6'd9, 6'd2);
        set_lane(1, 1'b1, 5'd2, 6'd10, 6'd3);
        cmplt(0, 4'd0);
        #1;
        n_chk++;
        if (o_disp_rdy !== 1'b0) begin
            n_fail++; $display("FAIL reset_rdy: got %b want 0", o_disp_rdy);
        end
        clk_edge();
        clk_edge();
        n_chk++;
        if (dut_out !== {64'h0, 2'b0, 10'h0, 12'h0, 5'd0, 1'b1}) begin
            n_fail++; $display("FAIL reset_state: got %h want cnt0 empty1 all-zero", dut_out);
        end
        i_rst = 1'b0;
        idle();
        #1;
        n_chk++;
        if ({o_disp_rdy, o_disp_tag} !== {1'b1, 8'h00}) begin
            n_fail++; $display("FAIL reset_release: got %b/%h want 1/00", o_disp_rdy, o_disp_tag);
        end
    endtask

    task automatic test_dispatch_pair();
        do_reset();
        set_lane(0, 1'b0, 5'd0, 6'd1, 6'd0);
        set_lane(1, 1'b0, 5'd0, 6'd2, 6'd0);
        #1;
        n_chk++;
        if (o_disp_tag !== {4'd1, 4'd0}) begin
            n_fail++; $display("FAIL pair_tags: got %h want 10", o_disp_tag);
        end
        clk_edge();
        idle();
        n_chk++;
        if ({o_rob_cnt, o_empty} !== {5'd2, 1'b0}) begin
            n_fail++; $display("FAIL pair_cnt: got cnt %0d empty %b want 2/0", o_rob_cnt, o_empty);
        end
        set_lane(1, 1'b0, 5'd0, 6'd3, 6'd0);
        #1;
        n_chk++;
        if (o_disp_tag[1] !== 4'd2) begin
            n_fail++; $display("FAIL sparse_tag: got %0d want 2", o_disp_tag[1]);
        end
        clk_edge();
    endtask

    task automatic test_single_retire();
        do_reset();
        set_lane(0, 1'b1, 5'd2, 6'd20, 6'd3);
        clk_edge();
        idle();
        cmplt(2, 4'd0);
        clk_edge();
        idle();
        n_chk++;
        if (o_ratc_we !== 2'b00) begin
            n_fail++; $display("FAIL single_early: got we %b want 00", o_ratc_we);
        end
        clk_edge();
        n_chk++;
        if ({o_free_pr, o_ratc_we, o_ratc_isa[0], o_ratc_pr[0]} !==
            {64'h8, 2'b01, 5'd2, 6'd20}) begin
            n_fail++; $display("FAIL single_retire: got free %h we %b isa %0d pr %0d want 8/01/2/20",
                               o_free_pr, o_ratc_we, o_ratc_isa[0], o_ratc_pr[0]);
        end
        clk_edge();
        n_chk++;
        if (dut_out !== {64'h0, 2'b0, 10'h0, 12'h0, 5'd0, 1'b1}) begin
            n_fail++; $display("FAIL single_pulse_end: got %h want all-zero empty", dut_out);
        end
    endtask

    task automatic test_out_of_order();
        do_reset();
        set_lane(0, 1'b1, 5'd5, 6'd30, 6'd7);
        set_lane(1, 1'b1, 5'd6, 6'd31, 6'd8);
        clk_edge();
        idle();
        cmplt(1, 4'd1);
        clk_edge();
        idle();
        for (int i = 0; i < 2; i++) begin
            clk_edge();
            n_chk++;
            if ({o_ratc_we, o_rob_cnt} !== {2'b00, 5'd2}) begin
                n_fail++; $display("FAIL ooo_blocked: got we %b cnt %0d want 00/2", o_ratc_we, o_rob_cnt);
            end
        end
        cmplt(0, 4'd0);
        cmplt(3, 4'd9);
        clk_edge();
        idle();
        clk_edge();
        n_chk++;
        if ({o_ratc_we, o_ratc_pr, o_free_pr, o_rob_cnt} !==
            {2'b11, 6'd31, 6'd30, 64'h180, 5'd0}) begin
            n_fail++; $display("FAIL ooo_retire: got we %b pr %h free %h cnt %0d", o_ratc_we, o_ratc_pr,
                               o_free_pr, o_rob_cnt);
        end
    endtask

    task automatic test_same_isa();
        do_reset();
        set_lane(0, 1'b1, 5'd7, 6'd40, 6'd10);
        set_lane(1, 1'b1, 5'd7, 6'd41, 6'd11);
        clk_edge();
        idle();
        set_lane(0, 1'b0, 5'd9, 6'd42, 6'd12);
        set_lane(1, 1'b1, 5'd4, 6'd43, 6'd13);
        cmplt(0, 4'd0); cmplt(1, 4'd1); cmplt(2, 4'd1);
        clk_edge();
        idle();
        cmplt(0, 4'd2); cmplt(1, 4'd3);
        clk_edge();
        idle();
        n_chk++;
        if ({o_ratc_we, o_ratc_isa, o_ratc_pr, o_free_pr} !==
            {2'b11, 5'd7, 5'd7, 6'd41, 6'd40, 64'hC00}) begin
            n_fail++; $display("FAIL same_isa: got we %b isa %h pr %h free %h", o_ratc_we, o_ratc_isa,
                               o_ratc_pr, o_free_pr);
        end
        clk_edge();
        n_chk++;
        if ({o_ratc_we, o_ratc_isa, o_ratc_pr, o_free_pr} !==
            {2'b10, 5'd4, 5'd0, 6'd43, 6'd0, 64'h2000}) begin
            n_fail++; $display("FAIL no_dst_lane: got we %b isa %h pr %h free %h", o_ratc_we,
                               o_ratc_isa, o_ratc_pr, o_free_pr);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            set_lane(0, 1'b1, 5'(i), 6'(2 * i), 6'(i));
            set_lane(1, 1'b1, 5'(i + 8), 6'(2 * i + 1), 6'(i + 32));
            clk_edge();
        end
        idle();
        #1;
        n_chk++;
        if ({o_rob_cnt, o_disp_rdy} !== {5'd14, 1'b1}) begin
            n_fail++; $display("FAIL full14: got cnt %0d rdy %b want 14/1", o_rob_cnt, o_disp_rdy);
        end
        cmplt(0, 4'd0); cmplt(1, 4'd1);
        clk_edge();
        idle();
        set_lane(0, 1'b1, 5'd1, 6'd50, 6'd51);
        set_lane(1, 1'b1, 5'd2, 6'd52, 6'd53);
        clk_edge();
        idle();
        n_chk++;
        if ({o_rob_cnt, o_ratc_we} !== {5'd14, 2'b11}) begin
            n_fail++; $display("FAIL full_swap: got cnt %0d we %b want 14/11", o_rob_cnt, o_ratc_we);
        end
        set_lane(0, 1'b1, 5'd3, 6'd54, 6'd55);
        clk_edge();
        idle();
        #1;
        n_chk++;
        if ({o_rob_cnt, o_disp_rdy} !== {5'd15, 1'b0}) begin
            n_fail++; $display("FAIL full15: got cnt %0d rdy %b want 15/0", o_rob_cnt, o_disp_rdy);
        end
        set_lane(0, 1'b1, 5'd3, 6'd56, 6'd57);
        set_lane(1, 1'b1, 5'd3, 6'd58, 6'd59);
        clk_edge();
        n_chk++;
        if (o_rob_cnt !== 5'd15 || dut_out !== exp_out()) begin
            n_fail++; $display("FAIL full_blocked: got cnt %0d (out %h) want 15 (%h)", o_rob_cnt,
                               dut_out, exp_out());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_lane(0, 1'b1, 5'(i), 6'(i + 16), 6'(i + 1));
            set_lane(1, 1'b1, 5'(i + 4), 6'(i + 24), 6'(i + 40));
            clk_edge();
        end
        idle();
        cmplt(0, 4'd1); cmplt(1, 4'd2); cmplt(2, 4'd3); cmplt(3, 4'd4);
        clk_edge();
        idle();
        cmplt(0, 4'd0);
        clk_edge();
        idle();
        n_chk++;
        if ({o_rob_cnt, o_free_pr} !== {5'd6, 64'h0}) begin
            n_fail++; $display("FAIL rstmid_pre: got cnt %0d free %h want 6/0", o_rob_cnt, o_free_pr);
        end
        i_rst = 1'b1;
        clk_edge();
        i_rst = 1'b0;
        n_chk++;
        if ({o_free_pr, o_ratc_we, o_rob_cnt, o_empty} !== {64'h0, 2'b00, 5'd0, 1'b1}) begin
            n_fail++; $display("FAIL rstmid_edge: got free %h we %b cnt %0d empty %b", o_free_pr,
                               o_ratc_we, o_rob_cnt, o_empty);
        end
        clk_edge();
        n_chk++;
        if ({o_free_pr, o_rob_cnt} !== {64'h0, 5'd0}) begin
            n_fail++; $display("FAIL rstmid_after: got free %h cnt %0d want 0/0", o_free_pr, o_rob_cnt);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            idle();
            if (cyc < 340) begin
                for (int i = 0; i < 2; i++) begin
                    if ($urandom_range(0, 2) != 0) begin
                        set_lane(i, 1'($urandom), 5'($urandom_range(0, 3)), pr_ctr,
                                 6'($urandom));
                        pr_ctr = pr_ctr + 6'd1;
                    end
                end
                for (int c = 0; c < 4; c++) begin
                    if ($urandom_range(0, 2) == 0) begin
                        if (q.size() > 0 && $urandom_range(0, 3) != 0)
                            cmplt(c, q[$urandom_range(0, q.size() - 1)].tag);
                        else
                            cmplt(c, 4'($urandom));
                    end
                end
            end else begin
                for (int c = 0; c < 4; c++) if (c < q.size()) cmplt(c, q[c].tag);
            end
            #1;
            n_chk++;
            if ({o_disp_rdy, o_disp_tag} !== {exp_rdy(), exp_tag(1), exp_tag(0)}) begin
                n_fail++; $display("FAIL rand_disp cyc %0d: got %b/%h want %b/%h%h", cyc, o_disp_rdy,
                                   o_disp_tag, exp_rdy(), exp_tag(1), exp_tag(0));
            end
            clk_edge();
            n_chk++;
            if (dut_out !== exp_out()) begin
                n_fail++; $display("FAIL rand_out cyc %0d: got %h want %h", cyc, dut_out, exp_out());
            end
        end
        n_chk++;
        if ({o_rob_cnt, o_empty} !== {5'd0, 1'b1}) begin
            n_fail++; $display("FAIL rand_drain: got cnt %0d empty %b want 0/1", o_rob_cnt, o_empty);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m_tail = 0;
        e_free = '0; e_we = '0; e_isa = '0; e_pr = '0;
        test_reset();
        test_dispatch_pair();
        test_single_retire();
        test_out_of_order();
        test_same_isa();
        test_full();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
